// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the req/gnt/rvalid/err bus: grants requests, reads/writes an
// internal word RAM and returns in-order responses a fixed number of cycles after grant.
module ibex_mem_responder #(
  parameter int          MemSize    = 65536,
  parameter logic [31:0] MemBase    = 32'h0010_0000,
  parameter int          RspLatency = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                req_i,
  output logic                                gnt_o,
  input  logic [31:0]                         addr_i,
  input  logic                                we_i,
  input  logic [3:0]                          be_i,
  input  logic [31:0]                         wdata_i,
  output logic                                rvalid_o,
  output logic [31:0]                         rdata_o,
  output logic                                err_o,
  input  logic                                gnt_stall_i,
  input  logic                                err_inject_i,
  output logic [$clog2(RspLatency+1)-1:0]     outstanding_o
);

  localparam int AddrW = $clog2(MemSize);
  localparam int Words = MemSize / 4;
  localparam int IdxW  = (AddrW > 2) ? AddrW - 2 : 1;
  localparam int CntW  = $clog2(RspLatency + 1);

  logic [31:0]           mem_q [Words];
  logic [31:0]           off;
  logic                  in_range;
  logic                  rsp_err;
  logic                  wr_en;
  logic [IdxW-1:0]       idx;

  logic [RspLatency-1:0] vld_q, vld_d;
  logic [RspLatency-1:0] err_q, err_d;
  logic [31:0]           data_q [RspLatency];
  logic [31:0]           data_d [RspLatency];
  logic [CntW-1:0]       cnt_q, cnt_d;

  assign gnt_o = req_i & ~gnt_stall_i & ~rst_i;

  // Offset from MemBase; the lower-bound test prevents wrap-around into the RAM.
  always_comb begin
    off      = addr_i - MemBase;
    in_range = (addr_i >= MemBase) && (off < 32'(MemSize));
    idx      = IdxW'(off >> 2);
    rsp_err  = ~in_range | err_inject_i;
    wr_en    = gnt_o & we_i & ~rsp_err;
  end

  // Grant edge: RAM lanes update here, so a read granted next cycle sees the new word.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    vld_d     = '0;
    err_d     = '0;
    vld_d[0]  = gnt_o;
    err_d[0]  = rsp_err;
    data_d[0] = (we_i | rsp_err) ? 32'h0 : mem_q[idx];
    for (int i = 1; i < RspLatency; i++) begin
      vld_d[i]  = vld_q[i-1];
      err_d[i]  = err_q[i-1];
      data_d[i] = data_q[i-1];
    end
    cnt_d = cnt_q + CntW'(gnt_o) - CntW'(vld_q[RspLatency-1]);
  end

  // Response pipeline: only valid bits and the counter are reset; payload is gated by valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    err_q <= err_d;
    for (int i = 0; i < RspLatency; i++) data_q[i] <= data_d[i];
  end

  assign rvalid_o      = vld_q[RspLatency-1];
  assign err_o         = rvalid_o & err_q[RspLatency-1];
  assign rdata_o       = rvalid_o ? data_q[RspLatency-1] : 32'h0;
  assign outstanding_o = cnt_q;

endmodule

// File: doc/ibex_mem_responder.md
Name: ibex_mem_responder

Overview:
- Memory-side responder for the core's instruction/data bus protocol (req/gnt/rvalid/err).
- Instances attach to the core's instr_* and data_* ports in simulation and FPGA top levels.
- Grants requests, performs word-addressed reads and byte-enabled writes on an internal RAM, and returns in-order responses after a fixed latency.
- Provides grant-stall and error-injection hooks for verification.

Parameters:
- MemSize, 65536, RAM size in bytes; power of two, ≥4.
- MemBase, 32'h0010_0000, byte address of RAM word 0; aligned to MemSize.
- RspLatency, 1, cycles from grant to rvalid; range 1..8.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  request valid; host holds addr/we/be/wdata stable until granted
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address; bits [1:0] ignored
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables, write lanes only
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, exactly one per grant
- rdata_o  out  32  read data; 0 for writes and errors
- err_o  out  1  response error, qualified by rvalid_o
- gnt_stall_i  in  1  test hook: suppresses gnt_o while high
- err_inject_i  in  1  test hook: the request granted while this is high responds with err_o=1
- outstanding_o  out  $clog2(RspLatency+1)  number of granted, not yet responded requests

Behaviour:
- Grant:
  - gnt_o = req_i & ~gnt_stall_i, combinational; forced 0 while rst_i is high.
  - Handshake completes in a cycle where req_i & gnt_o.
  - At most one grant per cycle; back-to-back grants are allowed every cycle.
  - Host has no rvalid backpressure; the responder never stalls a response.
- Address decode:
  - In range iff MemBase ≤ addr_i < MemBase+MemSize.
  - Word index = (addr_i − MemBase)[log2(MemSize)−1:2].
  - A request is an error if it is out of range or err_inject_i is high at grant.
- Write (granted, we_i=1, no error):
  - Each byte lane k with be_i[k]=1 is updated from wdata_i[8k+7:8k] at the grant clock edge.
  - be_i=0 is a legal no-op; the response is still issued with err_o=0.
- Read (granted, we_i=0, no error):
  - RAM word is sampled at the grant cycle.
  - A read granted in the cycle after a write to the same word returns the new data; in-order grant sampling guarantees read-after-write ordering.
- Error: no RAM update; response rdata_o=0, err_o=1.
- Response pipeline:
  - RspLatency-stage shift register of {valid, err, rdata}.
  - A request granted at cycle T drives rvalid_o=1 at cycle T+RspLatency for exactly one cycle, with rdata_o and err_o valid that cycle.
  - Responses are strictly in grant order.
  - With rvalid_o=0: rdata_o=0 and err_o=0.
- outstanding_o:
  - +1 on grant, −1 on rvalid_o, unchanged when both occur in the same cycle.
  - Never exceeds RspLatency.
- Reset:
  - Asynchronous assert clears the pipeline and counter.
  - Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, outstanding_o=0.
  - In-flight responses are dropped, never delivered after reset release.
  - RAM contents are not cleared by reset; initial contents are undefined (loadable via simulator backdoor).
  - Deassertion takes effect on the next clock edge; the first grant is possible in the first cycle after release.
- Simultaneous events:
  - A grant and a response in the same cycle are independent.
  - gnt_stall_i rising while req_i is high holds the request pending; no response is generated until it is granted.
- Wrap:
  - Addresses at the top of the range (MemBase+MemSize−4) are in range.
  - MemBase+MemSize and addresses below MemBase are errors.
  - No wrap-around into RAM.

Test Plan:
- RspLatency=1: write 0xDEADBEEF, be=4'hF to MemBase+0x10, then read the same address → gnt in the request cycle; read rvalid_o one cycle after its grant; rdata_o=0xDEADBEEF, err_o=0.
- Partial write be=4'b0101, wdata=0x11223344 over 0xDEADBEEF, then read → rdata_o=0xDE22BE44.
- RspLatency=3: 3 back-to-back reads of words holding 1, 2, 3 → rvalid_o high at cycles T+3..T+5 with rdata_o 1, 2, 3; outstanding_o peaks at 3.
- Read MemBase+MemSize, and separately MemBase−4 → err_o=1, rdata_o=0; write with err_inject_i=1 → err_o=1 and RAM word unchanged on readback.
- gnt_stall_i high for 4 cycles with req_i held → gnt_o=0 for those cycles, no rvalid_o; grant on the first cycle the stall drops, response RspLatency cycles later.
- RspLatency=3: assert rst_i with 2 requests outstanding → outputs immediately 0, outstanding_o=0, no rvalid_o after release; RAM data written before reset is still readable.
